// File: rtl/lcd_screen_pkg.sv
// Shared types and constants for the LCD screen arbitration path.
package lcd_screen_pkg;

  // Default pixel width: RGB565.
  localparam int LCD_PIX_W = 16;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } arb_state_t;

  // Common RGB565 colours used by the procedural screens.
  localparam logic [15:0] RGB565_BLACK  = 16'h0000;
  localparam logic [15:0] RGB565_WHITE  = 16'hFFFF;
  localparam logic [15:0] RGB565_RED    = 16'hF800;
  localparam logic [15:0] RGB565_GREEN  = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE   = 16'h001F;
  localparam logic [15:0] RGB565_YELLOW = 16'hFFE0;
  localparam logic [15:0] RGB565_ORANGE = 16'hFD20;
  localparam logic [15:0] RGB565_GREY   = 16'h8410;

  // Pack 8-bit-per-channel colour into RGB565.
  function automatic logic [15:0] rgb565(input logic [7:0] r,
                                         input logic [7:0] g,
                                         input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/lcd_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins, DEFAULT when idle.
module lcd_prio_enc #(
  parameter int unsigned N       = 4,
  parameter int unsigned DEFAULT = 0,
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx
);

  logic found;

  // Scan upward so the first hit (highest priority) is kept.
  always_comb begin
    idx   = IDX_W'(DEFAULT);
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_screen_arbiter.sv
// Selects which pixel generator drives the LCD controller; switches only on
// frame boundaries with a minimum dwell, plus a debug force path.
module lcd_screen_arbiter
  import lcd_screen_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int PIX_W       = LCD_PIX_W,
  parameter int DEFAULT_SRC = 0,
  parameter int HOLD_FRAMES = 2,
  localparam int IDX_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       src_req,
  input  logic [N_SRC*PIX_W-1:0] src_pixel,
  input  logic [N_SRC-1:0]       src_avail,
  input  logic                   frame_start,
  input  logic                   force_en,
  input  logic [IDX_W-1:0]       force_idx,
  output logic [PIX_W-1:0]       pixel_out,
  output logic                   pixel_avail,
  output logic [IDX_W-1:0]       active_idx,
  output logic [N_SRC-1:0]       active_oh,
  output logic                   pending,
  output logic                   switch_pulse
);

  localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  arb_state_t        state;
  logic [IDX_W-1:0]  target;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_inc;
  logic              hold_met;
  logic              force_ok;

  lcd_prio_enc #(
    .N       (N_SRC),
    .DEFAULT (DEFAULT_SRC)
  ) u_prio (
    .req (src_req),
    .idx (target)
  );

  // Force index validity and frame-dwell qualification.
  // The dwell test uses the count including the current frame_start, so the
  // HOLD_FRAMES-th frame after a switch is already allowed to switch again.
  always_comb begin
    force_ok = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (force_idx == IDX_W'(i)) force_ok = force_en;
    end
    hold_inc = hold_cnt;
    if (frame_start && (int'(hold_cnt) < HOLD_FRAMES)) hold_inc = hold_cnt + HOLD_W'(1);
    hold_met = frame_start && (int'(hold_inc) >= HOLD_FRAMES);
  end

  // Arbitration FSM with registered index, one-hot, pending and switch pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      active_idx   <= IDX_W'(DEFAULT_SRC);
      active_oh    <= N_SRC'(1) << DEFAULT_SRC;
      pending      <= 1'b0;
      switch_pulse <= 1'b0;
      hold_cnt     <= HOLD_W'(HOLD_FRAMES);
    end else begin
      switch_pulse <= 1'b0;
      hold_cnt     <= hold_inc;
      if (force_ok) begin
        active_idx   <= force_idx;
        active_oh    <= N_SRC'(1) << force_idx;
        hold_cnt     <= '0;
        switch_pulse <= (force_idx != active_idx);
        pending      <= 1'b0;
        state        <= S_RUN;
      end else begin
        unique case (state)
          S_IDLE: begin
            pending <= 1'b0;
            state   <= S_RUN;
          end
          S_RUN: begin
            if (target != active_idx) begin
              pending <= 1'b1;
              state   <= S_PEND;
            end
          end
          S_PEND: begin
            if (target == active_idx) begin
              pending <= 1'b0;
              state   <= S_RUN;
            end else if (hold_met) begin
              active_idx   <= target;
              active_oh    <= N_SRC'(1) << target;
              hold_cnt     <= '0;
              switch_pulse <= 1'b1;
              pending      <= 1'b0;
              state        <= S_RUN;
            end
          end
          default: begin
            pending <= 1'b0;
            state   <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Pixel path follows the registered index with no extra pipeline stage.
  always_comb begin
    pixel_out   = '0;
    pixel_avail = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (active_idx == IDX_W'(i)) begin
        pixel_out   = src_pixel[i*PIX_W +: PIX_W];
        pixel_avail = src_avail[i];
      end
    end
  end

endmodule

// File: tb/tb_lcd_screen_arbiter.sv
// Bench for lcd_screen_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of the arbitration rules.
module tb_lcd_screen_arbiter;

  localparam int N    = 4;
  localparam int PW   = 16;
  localparam int DEF  = 0;
  localparam int HOLD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  src_req = '0;
  logic [N*PW-1:0] src_pixel = '0;
  logic [N-1:0]  src_avail = '1;
  logic          frame_start = 1'b0;
  logic          force_en = 1'b0;
  logic [1:0]    force_idx = '0;
  logic [PW-1:0] pixel_out;
  logic          pixel_avail;
  logic [1:0]    active_idx;
  logic [N-1:0]  active_oh;
  logic          pending;
  logic          switch_pulse;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  // Behavioural model state.
  int m_active  = DEF;
  int m_hold    = HOLD;
  int m_pulse   = 0;
  bit m_pending = 1'b0;
  bit m_idle    = 1'b1;
  int m_tgt, m_held;

  logic [PW-1:0] px0;
  int force_left = 0;

  lcd_screen_arbiter #(
    .N_SRC       (N),
    .PIX_W       (PW),
    .DEFAULT_SRC (DEF),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_req      (src_req),
    .src_pixel    (src_pixel),
    .src_avail    (src_avail),
    .frame_start  (frame_start),
    .force_en     (force_en),
    .force_idx    (force_idx),
    .pixel_out    (pixel_out),
    .pixel_avail  (pixel_avail),
    .active_idx   (active_idx),
    .active_oh    (active_oh),
    .pending      (pending),
    .switch_pulse (switch_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int lowest_req(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return DEF;
  endfunction

  // Reference: which screen should be up, from the arbitration rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active  = DEF;
      m_hold    = HOLD;
      m_pulse   = 0;
      m_pending = 1'b0;
      m_idle    = 1'b1;
    end else begin
      m_tgt   = lowest_req(src_req);
      m_held  = frame_start ? ((m_hold + 1 > HOLD) ? HOLD : m_hold + 1) : m_hold;
      m_pulse = 0;
      if (force_en && int'(force_idx) < N) begin
        m_pulse   = (int'(force_idx) != m_active) ? 1 : 0;
        m_active  = int'(force_idx);
        m_hold    = 0;
        m_pending = 1'b0;
        m_idle    = 1'b0;
      end else begin
        m_hold = m_held;
        if (m_idle) m_idle = 1'b0;
        else if (!m_pending) m_pending = (m_tgt != m_active);
        else if (m_tgt == m_active) m_pending = 1'b0;
        else if (frame_start && m_held >= HOLD) begin
          m_active  = m_tgt;
          m_hold    = 0;
          m_pulse   = 1;
          m_pending = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    if (chk_en) begin
      #2;
      chk("active_idx", 32'(active_idx), 32'(m_active));
      chk("active_oh", 32'(active_oh), 32'(1) << m_active);
      chk("pending", 32'(pending), 32'(m_pending));
      chk("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
      chk("pixel_out", 32'(pixel_out), 32'(src_pixel[m_active*PW +: PW]));
      chk("pixel_avail", 32'(pixel_avail), 32'(src_avail[m_active]));
    end
  end

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  initial begin
    src_pixel = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) settle();

    // Reset release with no requests.
    chk("rst_idx", 32'(active_idx), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_pulse", 32'(switch_pulse), 32'd0);
    chk("rst_pix", 32'(pixel_out), 32'h1111);

    // Request source 3; first switch not blocked by dwell.
    @(negedge clk); src_req = 4'b1000;
    settle();
    chk("s2_pend", 32'(pending), 32'd1);
    chk("s2_idx_wait", 32'(active_idx), 32'd0);
    @(negedge clk); frame_start = 1'b1;
    settle();
    chk("s2_idx", 32'(active_idx), 32'd3);
    chk("s2_pulse", 32'(switch_pulse), 32'd1);
    chk("s2_pix", 32'(pixel_out), 32'h4444);

    // Immediately request source 2: needs two frame_starts.
    @(negedge clk); frame_start = 1'b0; src_req = 4'b0100;
    settle();
    chk("s3_pend", 32'(pending), 32'd1);
    @(negedge clk); frame_start = 1'b1;
    settle();
    chk("s3_idx_fs1", 32'(active_idx), 32'd3);
    chk("s3_pend_fs1", 32'(pending), 32'd1);
    @(negedge clk); frame_start = 1'b0;
    @(negedge clk); frame_start = 1'b1;
    settle();
    chk("s3_idx_fs2", 32'(active_idx), 32'd2);
    chk("s3_pulse", 32'(switch_pulse), 32'd1);

    // Higher-priority request withdrawn before the frame boundary.
    @(negedge clk); frame_start = 1'b0; src_req = 4'b0110;
    settle();
    chk("s4_pend", 32'(pending), 32'd1);
    @(negedge clk); src_req = 4'b0100;
    settle();
    chk("s4_pend_clr", 32'(pending), 32'd0);
    chk("s4_idx", 32'(active_idx), 32'd2);
    chk("s4_pulse", 32'(switch_pulse), 32'd0);

    // Force overrides a qualifying frame_start switch.
    @(negedge clk); force_en = 1'b1; force_idx = 2'd0; src_req = 4'b0010;
    settle();
    chk("s5_force0", 32'(active_idx), 32'd0);
    chk("s5_force0_pulse", 32'(switch_pulse), 32'd1);
    @(negedge clk); force_en = 1'b0;
    settle();
    chk("s5_pend", 32'(pending), 32'd1);
    @(negedge clk); frame_start = 1'b1;
    settle();
    chk("s5_hold_block", 32'(active_idx), 32'd0);
    @(negedge clk); frame_start = 1'b0;
    @(negedge clk); frame_start = 1'b1; force_en = 1'b1; force_idx = 2'd2;
    settle();
    chk("s5_idx", 32'(active_idx), 32'd2);
    chk("s5_oh", 32'(active_oh), 32'b0100);
    chk("s5_pulse", 32'(switch_pulse), 32'd1);
    @(negedge clk); frame_start = 1'b0; force_en = 1'b0;
    settle();
    chk("s5_pulse_once", 32'(switch_pulse), 32'd0);
    chk("s5_repend", 32'(pending), 32'd1);

    // Asynchronous reset while a switch is pending.
    @(negedge clk); src_avail = 4'b1110;
    #2 rst = 1'b1;
    #1;
    px0 = src_pixel[PW-1:0];
    chk("s6_idx", 32'(active_idx), 32'd0);
    chk("s6_pend", 32'(pending), 32'd0);
    chk("s6_avail", 32'(pixel_avail), 32'd0);
    chk("s6_pix", 32'(pixel_out), 32'(px0));
    repeat (2) @(negedge clk);
    rst = 1'b0; src_avail = '1;

    // Randomized traffic.
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) src_req = 4'($urandom);
      frame_start = ($urandom_range(0, 5) == 0);
      if (force_left > 0) begin
        force_en = 1'b1;
        force_left--;
      end else if ($urandom_range(0, 39) == 0) begin
        force_en   = 1'b1;
        force_idx  = 2'($urandom);
        force_left = $urandom_range(0, 2);
      end else begin
        force_en = 1'b0;
      end
      src_avail = 4'($urandom);
      if ($urandom_range(0, 3) == 0) src_pixel = {$urandom, $urandom};
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
